qpsk_frame_sync: RTL and testbench

QPSK_FRAME_SYNC -- requirements
Module: qpsk_frame_sync

---
 rtl/qpsk_frame_sync.sv | 187 ++++++++++++++++++
 tb/tb_qpsk_frame_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_frame_sync.sv
// ---------------------------------------------------------------------------
// qpsk_frame_sync
//
// Hard-decision QPSK frame synchroniser. Each valid symbol is sliced to a
// dibit {sign(I), sign(Q)} and shifted into a 32-bit window. While searching,
// the window (including the current symbol) is compared against the attached
// sync marker and its complement by Hamming distance. Once locked, the
// following FRAME_BYTES bytes are assembled MSB-first (phase-corrected when
// the complement marker was seen) and pushed into a small output FIFO with a
// valid/ready pop interface.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   I_in, Q_in : signed I/Q symbols (DATA_WIDTH bits)
//   valid_in   : I_in/Q_in carry a symbol this cycle (no backpressure)
//   byte_out   : FIFO head byte (0 when empty)
//   byte_valid : FIFO not empty
//   byte_ready : consumer accepts byte_out
//   locked     : frame state is LOCKED
//   inverted   : current frame was acquired on the complemented marker
//   overflow   : sticky, a completed byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module qpsk_frame_sync #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
    parameter int unsigned MAX_ERR     = 2,
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] I_in,
    input  logic [DATA_WIDTH-1:0] Q_in,
    input  logic                  valid_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  locked,
    output logic                  inverted,
    output logic                  overflow
);

    localparam logic [0:0] S_SEARCH = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam int unsigned BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = PW + 1;

    function automatic logic [5:0] f_popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            n = n + {5'd0, v[k]};
        end
        return n;
    endfunction

    // Framing state
    logic [0:0]     r_state;
    logic [31:0]    r_shift;
    logic           r_inverted;
    logic [1:0]     r_dibit_cnt;
    logic [BCW-1:0] r_byte_cnt;
    logic [5:0]     r_byte_acc;

    // FIFO state
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    logic [1:0]     w_dibit;
    logic [1:0]     w_data_dibit;
    logic [31:0]    w_next_shift;
    logic [5:0]     w_dist_true;
    logic [5:0]     w_dist_inv;
    logic           w_match_true;
    logic           w_match_inv;
    logic           w_push;
    logic [7:0]     w_byte;
    logic           w_frame_end;
    logic           w_full;
    logic           w_pop;
    logic           w_wr;

    // Signed compare slices on the sign bit; a zero sample decides as 0.
    assign w_dibit      = {($signed(I_in) < 0), ($signed(Q_in) < 0)};
    assign w_data_dibit = w_dibit ^ {r_inverted, r_inverted};
    assign w_next_shift = {r_shift[29:0], w_dibit};

    assign w_dist_true  = f_popcount(w_next_shift ^ SYNC_WORD);
    assign w_dist_inv   = f_popcount(w_next_shift ^ ~SYNC_WORD);
    assign w_match_true = (w_dist_true <= 6'(MAX_ERR));
    assign w_match_inv  = (w_dist_inv  <= 6'(MAX_ERR));

    assign w_push      = valid_in && (r_state == S_LOCKED) && (r_dibit_cnt == 2'd3);
    assign w_byte      = {r_byte_acc, w_data_dibit};
    assign w_frame_end = w_push && (r_byte_cnt == BCW'(FRAME_BYTES - 1));

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = byte_valid && byte_ready;
    // A same-edge pop frees the slot, so a push on a full FIFO still lands.
    assign w_wr   = w_push && (!w_full || w_pop);

    // -----------------------------------------------------------------------
    // Framing FSM, shift window and byte assembly
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_shift     <= '0;
            r_inverted  <= 1'b0;
            r_dibit_cnt <= '0;
            r_byte_cnt  <= '0;
            r_byte_acc  <= '0;
        end else if (valid_in) begin
            r_shift <= w_next_shift;
            if (r_state == S_SEARCH) begin
                r_dibit_cnt <= '0;
                r_byte_cnt  <= '0;
                if (w_match_true) begin
                    r_state    <= S_LOCKED;
                    r_inverted <= 1'b0;
                end else if (w_match_inv) begin
                    r_state    <= S_LOCKED;
                    r_inverted <= 1'b1;
                end
            end else begin
                r_byte_acc  <= {r_byte_acc[3:0], w_data_dibit};
                r_dibit_cnt <= r_dibit_cnt + 2'd1;
                if (w_push) begin
                    r_byte_cnt <= r_byte_cnt + BCW'(1);
                end
                if (w_frame_end) begin
                    r_state     <= S_SEARCH;
                    r_inverted  <= 1'b0;
                    r_dibit_cnt <= '0;
                    r_byte_cnt  <= '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head byte is gated so it reads 0 while the FIFO is empty or in reset.
    assign byte_valid = (r_count != '0);
    assign byte_out   = byte_valid ? r_mem[r_rptr] : 8'h00;
    assign locked     = (r_state == S_LOCKED);
    assign inverted   = r_inverted;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
module tb_qpsk_frame_sync;

    localparam logic [31:0] MARKER = 32'h1ACFFC1D;

    logic        clk;
    logic        rst;
    logic [15:0] I_in;
    logic [15:0] Q_in;
    logic        valid_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        locked;
    logic        inverted;
    logic        overflow;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];
    int          gap;
    bit          neg;

    qpsk_frame_sync #(
        .DATA_WIDTH (16),
        .SYNC_WORD  (32'h1ACFFC1D),
        .MAX_ERR    (2),
        .FRAME_BYTES(16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .I_in      (I_in),
        .Q_in      (Q_in),
        .valid_in  (valid_in),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .locked    (locked),
        .inverted  (inverted),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output byte.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h, required no output (t=%0t)", byte_out, $time);
            end else begin
                check("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic sym(input logic [1:0] d);
        logic signed [15:0] iv;
        logic signed [15:0] qv;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        iv = d[1] ? -16'sd8192 : 16'sd8192;
        qv = d[0] ? -16'sd8192 : 16'sd8192;
        if (neg) begin
            iv = -iv;
            qv = -qv;
        end
        I_in     = iv;
        Q_in     = qv;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_marker_part(input logic [31:0] w, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            sym(w[31-2*k -: 2]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            sym(b[7-2*k -: 2]);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check({tag, "_rst_byte_out"},   {24'd0, byte_out}, 32'h0);
        check({tag, "_rst_byte_valid"}, {31'd0, byte_valid}, 32'h0);
        check({tag, "_rst_locked"},     {31'd0, locked}, 32'h0);
        check({tag, "_rst_inverted"},   {31'd0, inverted}, 32'h0);
        check({tag, "_rst_overflow"},   {31'd0, overflow}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Marker, 16 data bytes 0x00..0x0F, all expected at the output.
    task automatic good_frame(input string name, input logic [31:0] mk, input logic inv_exp);
        send_marker_part(mk, 0, 14);
        check({name, "_locked_pre"}, {31'd0, locked}, 32'h0);
        send_marker_part(mk, 15, 15);
        check({name, "_locked"},   {31'd0, locked}, 32'h1);
        check({name, "_inverted"}, {31'd0, inverted}, {31'd0, inv_exp});
        for (int b = 0; b < 16; b++) begin
            exp_q.push_back(8'(b));
            if (b == 15) begin
                sym(2'(b >> 6));
                sym(2'(b >> 4));
                sym(2'(b >> 2));
                check({name, "_locked_d63"}, {31'd0, locked}, 32'h1);
                sym(2'(b));
            end else begin
                send_byte(8'(b));
            end
        end
        check({name, "_unlocked_d64"}, {31'd0, locked}, 32'h0);
        check({name, "_inverted_end"}, {31'd0, inverted}, 32'h0);
        wait_drain(name);
        check({name, "_overflow"}, {31'd0, overflow}, 32'h0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        gap        = 0;
        neg        = 1'b0;
        rst        = 1'b1;
        I_in       = '0;
        Q_in       = '0;
        valid_in   = 1'b0;
        byte_ready = 1'b1;
        idle(3);
        check("init_byte_valid", {31'd0, byte_valid}, 32'h0);
        check("init_locked",     {31'd0, locked}, 32'h0);
        check("init_overflow",   {31'd0, overflow}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Basic frame
        good_frame("basic", MARKER, 1'b0);

        // Two marker bit errors still lock
        do_reset("e2");
        good_frame("err2", MARKER ^ 32'h0000_0101, 1'b0);

        // Three marker bit errors: no lock, no output
        do_reset("e3");
        send_marker_part(MARKER ^ 32'h0001_0101, 0, 15);
        check("err3_locked", {31'd0, locked}, 32'h0);
        for (int b = 0; b < 16; b++) send_byte(8'(b));
        idle(10);
        check("err3_locked_end", {31'd0, locked}, 32'h0);
        check("err3_byte_valid", {31'd0, byte_valid}, 32'h0);

        // Phase inversion
        do_reset("inv");
        neg = 1'b1;
        good_frame("inv", MARKER, 1'b1);
        neg = 1'b0;

        // Backpressure and overflow
        do_reset("bp");
        byte_ready = 1'b0;
        send_marker_part(MARKER, 0, 15);
        for (int b = 0; b < 4; b++) send_byte(8'(b));
        check("bp_byte_valid",  {31'd0, byte_valid}, 32'h1);
        check("bp_byte_out",    {24'd0, byte_out}, 32'h00);
        check("bp_overflow_b4", {31'd0, overflow}, 32'h0);
        send_byte(8'h04);
        check("bp_overflow_b5", {31'd0, overflow}, 32'h1);
        check("bp_byte_out_hold", {24'd0, byte_out}, 32'h00);
        for (int b = 5; b < 16; b++) send_byte(8'(b));
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(b));
        byte_ready = 1'b1;
        wait_drain("bp");
        check("bp_byte_valid_end", {31'd0, byte_valid}, 32'h0);
        check("bp_overflow_sticky", {31'd0, overflow}, 32'h1);

        // Mid-frame reset discards FIFO and partial frame
        do_reset("mid0");
        byte_ready = 1'b0;
        send_marker_part(MARKER, 0, 15);
        for (int b = 0; b < 5; b++) send_byte(8'(b));
        check("mid_byte_valid_pre", {31'd0, byte_valid}, 32'h1);
        check("mid_overflow_pre",   {31'd0, overflow}, 32'h1);
        do_reset("mid");
        byte_ready = 1'b1;
        for (int b = 5; b < 16; b++) send_byte(8'(b));
        idle(10);
        check("mid_byte_valid_end", {31'd0, byte_valid}, 32'h0);
        check("mid_locked_end",     {31'd0, locked}, 32'h0);

        // Sparse valid_in, one symbol in four cycles
        do_reset("sp");
        gap = 3;
        good_frame("sparse", MARKER, 1'b0);
        gap = 0;

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always reaches its summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
